// File: rtl/fp_operand_byte_loader_if.sv
// Operand-entry bus: button/switch inputs toward the loader and the
// committed operand pair plus entry status coming back out.
interface fp_operand_byte_loader_if #(
   parameter int OP_W = 32
);
   logic            btn;
   logic            clr;
   logic [7:0]      Din;
   logic [OP_W-1:0] FA;
   logic [OP_W-1:0] FB;
   logic [3:0]      byte_idx;
   logic            busy;
   logic            ready;
   logic            commit;

   // Side that presses the button and consumes the operands.
   modport master (
      output btn, clr, Din,
      input  FA, FB, byte_idx, busy, ready, commit
   );

   // The loader itself.
   modport slave (
      input  btn, clr, Din,
      output FA, FB, byte_idx, busy, ready, commit
   );
endinterface

// File: rtl/fp_operand_byte_loader.sv
// Byte-serial operand entry for the FP adder. Each button press captures one
// switch byte, MSB first, into shadow A then shadow B. Both operands are
// copied to FA/FB on the same edge as the final byte, so the combinational
// adder downstream only ever sees complete operand pairs.
module fp_operand_byte_loader #(
   parameter int BYTES_PER_OP = 4,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   fp_operand_byte_loader_if.slave     bus
);

   localparam int         OP_W       = 8 * BYTES_PER_OP;
   localparam logic [3:0] LAST_A_IDX = 4'(BYTES_PER_OP - 1);
   localparam logic [3:0] FIRST_B_IDX = 4'(BYTES_PER_OP);
   localparam logic [3:0] LAST_B_IDX = 4'(2 * BYTES_PER_OP - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_A = 2'd1,
      LOAD_B = 2'd2,
      DONE   = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Button synchroniser and rising-edge detector
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   press;

   // Shift the asynchronous button level through the synchroniser, then
   // keep one more flop so a held button yields a single press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign press = sync_q[SYNC_STAGES-1] & ~prev_q;

   // ------------------------------------------------------------------
   // Byte placement: byte k of an operand lands MSB first, i.e. k=0 is
   // the top byte. Only the addressed byte lane is replaced.
   // ------------------------------------------------------------------
   function automatic logic [OP_W-1:0] place_byte(
      input logic [OP_W-1:0] base,
      input logic [7:0]      b,
      input logic [3:0]      k
   );
      int              sh;
      logic [OP_W-1:0] mask;
      sh   = 8 * (BYTES_PER_OP - 1 - int'(k));
      mask = OP_W'(8'hFF) << sh;
      return (base & ~mask) | (OP_W'(b) << sh);
   endfunction

   // ------------------------------------------------------------------
   // Entry state machine and all registered outputs
   // ------------------------------------------------------------------
   state_t          state_q;
   logic [OP_W-1:0] sha_q;
   logic [OP_W-1:0] shb_q;
   logic [OP_W-1:0] fa_q;
   logic [OP_W-1:0] fb_q;
   logic [3:0]      idx_q;
   logic            busy_q;
   logic            ready_q;
   logic            commit_q;
   // Remembers that a pair has committed since reset, so an aborted
   // entry can fall back to DONE with ready restored.
   logic            had_pair_q;

   // Candidate shadow values for a capture this cycle. The first byte of
   // each operand starts from zero so stale bytes never leak through.
   logic [OP_W-1:0] sha_d;
   logic [OP_W-1:0] shb_d;
   logic [3:0]      b_idx;

   assign b_idx = idx_q - FIRST_B_IDX;

   // Shadow update values, selected by the FSM only when it captures.
   always_comb begin
      sha_d = place_byte((state_q == LOAD_A) ? sha_q : '0, bus.Din,
                         (state_q == LOAD_A) ? idx_q : 4'd0);
      shb_d = place_byte((idx_q == FIRST_B_IDX) ? '0 : shb_q, bus.Din, b_idx);
   end

   // Single registered FSM: captures, abort handling and the commit pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sha_q      <= '0;
         shb_q      <= '0;
         fa_q       <= '0;
         fb_q       <= '0;
         idx_q      <= 4'd0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
         commit_q   <= 1'b0;
         had_pair_q <= 1'b0;
      end else begin
         commit_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               // Abort has no meaning outside an entry; a press starts one.
               if (press) begin
                  sha_q   <= sha_d;
                  idx_q   <= 4'd1;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
                  state_q <= (LAST_A_IDX == 4'd0) ? LOAD_B : LOAD_A;
               end
            end

            LOAD_A: begin
               if (bus.clr) begin
                  // Abort wins over a simultaneous press.
                  sha_q   <= '0;
                  shb_q   <= '0;
                  idx_q   <= 4'd0;
                  busy_q  <= 1'b0;
                  ready_q <= had_pair_q;
                  state_q <= had_pair_q ? DONE : IDLE;
               end else if (press) begin
                  sha_q <= sha_d;
                  idx_q <= idx_q + 4'd1;
                  if (idx_q == LAST_A_IDX) begin
                     state_q <= LOAD_B;
                  end
               end
            end

            LOAD_B: begin
               if (bus.clr) begin
                  sha_q   <= '0;
                  shb_q   <= '0;
                  idx_q   <= 4'd0;
                  busy_q  <= 1'b0;
                  ready_q <= had_pair_q;
                  state_q <= had_pair_q ? DONE : IDLE;
               end else if (press) begin
                  shb_q <= shb_d;
                  if (idx_q == LAST_B_IDX) begin
                     // Final byte: both operands commit on this edge.
                     fa_q       <= sha_q;
                     fb_q       <= shb_d;
                     commit_q   <= 1'b1;
                     ready_q    <= 1'b1;
                     had_pair_q <= 1'b1;
                     busy_q     <= 1'b0;
                     idx_q      <= 4'd0;
                     state_q    <= DONE;
                  end else begin
                     idx_q <= idx_q + 4'd1;
                  end
               end
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               idx_q   <= 4'd0;
            end
         endcase
      end
   end

   assign bus.FA       = fa_q;
   assign bus.FB       = fb_q;
   assign bus.byte_idx = idx_q;
   assign bus.busy     = busy_q;
   assign bus.ready    = ready_q;
   assign bus.commit   = commit_q;

endmodule

// File: tb/tb_fp_operand_byte_loader.sv
// Bench for the operand byte loader. The reference model keeps the bytes of
// the current entry in a queue and assembles operands from it once a full
// pair has been entered.
module tb_fp_operand_byte_loader;

   localparam int BPO  = 4;
   localparam int OP_W = 8 * BPO;
   localparam int NB   = 2 * BPO;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   fp_operand_byte_loader_if #(.OP_W(OP_W)) bus ();

   fp_operand_byte_loader #(
      .BYTES_PER_OP (BPO),
      .SYNC_STAGES  (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // Reference model state.
   logic [7:0]      q[$];
   logic [OP_W-1:0] exp_fa = '0;
   logic [OP_W-1:0] exp_fb = '0;
   bit              had_pair = 1'b0;
   int              exp_commits = 0;

   // Commit pulse observers.
   int commit_seen = 0;
   int commit_long = 0;
   bit commit_prev = 1'b0;

   always @(negedge clk) begin
      if (rst_n && bus.commit) commit_seen++;
      if (commit_prev && bus.commit) commit_long++;
      commit_prev = bus.commit;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   task automatic model_press(input logic [7:0] v);
      q.push_back(v);
      if (q.size() == NB) begin
         exp_fa = '0;
         exp_fb = '0;
         for (int i = 0; i < BPO; i++) begin
            exp_fa = {exp_fa[OP_W-9:0], q[i]};
            exp_fb = {exp_fb[OP_W-9:0], q[BPO+i]};
         end
         q.delete();
         had_pair = 1'b1;
         exp_commits++;
      end
   endtask

   task automatic model_reset();
      q.delete();
      exp_fa   = '0;
      exp_fb   = '0;
      had_pair = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   task automatic drive_press(input logic [7:0] v, input int hold);
      @(negedge clk);
      bus.Din = v;
      bus.btn = 1'b1;
      repeat (hold) @(negedge clk);
      bus.btn = 1'b0;
      repeat (4) @(negedge clk);
      model_press(v);
   endtask

   task automatic drive_clr();
      @(negedge clk);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      @(negedge clk);
      q.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      vectors++;
      if (bus.FA !== '0 || bus.FB !== '0) begin
         errors++; $display("FAIL reset_ops: FA=%h FB=%h want 0/0", bus.FA, bus.FB);
      end
      vectors++;
      if ({bus.byte_idx, bus.busy, bus.ready, bus.commit} !== 7'd0) begin
         errors++; $display("FAIL reset_status: idx=%0d busy=%b ready=%b commit=%b want all 0",
                            bus.byte_idx, bus.busy, bus.ready, bus.commit);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({bus.byte_idx, bus.busy, bus.ready} !== 6'd0) begin
         errors++; $display("FAIL reset_release: idx=%0d busy=%b ready=%b want 0",
                            bus.byte_idx, bus.busy, bus.ready);
      end
      $display("reset: done");
   endtask

   task automatic test_basic();
      logic [7:0] bytes [NB] = '{8'h3F, 8'hC0, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < NB; i++) begin
         drive_press(bytes[i], 4);
         vectors++;
         if (bus.byte_idx !== 4'(q.size()) || bus.busy !== (q.size() != 0)) begin
            errors++; $display("FAIL basic_idx[%0d]: idx=%0d busy=%b want %0d/%b",
                               i, bus.byte_idx, bus.busy, q.size(), q.size() != 0);
         end
         vectors++;
         if (bus.FA !== exp_fa || bus.FB !== exp_fb || bus.ready !== (had_pair && q.size() == 0)) begin
            errors++; $display("FAIL basic_ops[%0d]: FA=%h FB=%h ready=%b want %h %h %b",
                               i, bus.FA, bus.FB, bus.ready, exp_fa, exp_fb, had_pair && q.size() == 0);
         end
         vectors++;
         if (commit_seen !== exp_commits) begin
            errors++; $display("FAIL basic_commits[%0d]: got %0d want %0d", i, commit_seen, exp_commits);
         end
         $display("basic: byte %0d = %h idx=%0d", i, bytes[i], bus.byte_idx);
      end
      vectors++;
      if (bus.FA !== 32'h3FC00000 || bus.FB !== 32'h40000000 || bus.ready !== 1'b1) begin
         errors++; $display("FAIL basic_final: FA=%h FB=%h ready=%b want 3fc00000 40000000 1",
                            bus.FA, bus.FB, bus.ready);
      end
   endtask

   task automatic test_hold();
      @(negedge clk);
      bus.Din = 8'hA5;
      bus.btn = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (bus.byte_idx !== 4'd0) begin
         errors++; $display("FAIL hold_early: idx=%0d want 0 before third edge", bus.byte_idx);
      end
      @(negedge clk);
      model_press(8'hA5);
      vectors++;
      if (bus.byte_idx !== 4'd1 || bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
         errors++; $display("FAIL hold_capture: idx=%0d busy=%b ready=%b want 1/1/0",
                            bus.byte_idx, bus.busy, bus.ready);
      end
      repeat (47) @(negedge clk);
      bus.btn = 1'b0;
      repeat (4) @(negedge clk);
      vectors++;
      if (bus.byte_idx !== 4'(q.size())) begin
         errors++; $display("FAIL hold_single: idx=%0d want %0d", bus.byte_idx, q.size());
      end
      $display("hold: 50-cycle press idx=%0d", bus.byte_idx);
   endtask

   task automatic test_clr();
      drive_clr();
      vectors++;
      if (bus.byte_idx !== 4'd0 || bus.busy !== 1'b0 || bus.ready !== 1'b1) begin
         errors++; $display("FAIL clr_abort1: idx=%0d busy=%b ready=%b want 0/0/1",
                            bus.byte_idx, bus.busy, bus.ready);
      end
      for (int i = 0; i < 3; i++) drive_press(8'(8'h10 + i), 3);
      vectors++;
      if (bus.byte_idx !== 4'd3 || bus.ready !== 1'b0) begin
         errors++; $display("FAIL clr_pre: idx=%0d ready=%b want 3/0", bus.byte_idx, bus.ready);
      end
      drive_clr();
      vectors++;
      if (bus.byte_idx !== 4'd0 || bus.busy !== 1'b0 || bus.ready !== 1'b1 ||
          bus.FA !== 32'h3FC00000 || bus.FB !== 32'h40000000) begin
         errors++; $display("FAIL clr_abort3: idx=%0d busy=%b ready=%b FA=%h FB=%h want 0/0/1 3fc00000 40000000",
                            bus.byte_idx, bus.busy, bus.ready, bus.FA, bus.FB);
      end
      drive_clr();
      vectors++;
      if (bus.byte_idx !== 4'd0 || bus.ready !== 1'b1 || bus.FA !== exp_fa) begin
         errors++; $display("FAIL clr_done_noeffect: idx=%0d ready=%b FA=%h want 0/1 %h",
                            bus.byte_idx, bus.ready, bus.FA, exp_fa);
      end
      $display("clr: aborts checked ready=%b", bus.ready);
   endtask

   task automatic test_clr_press();
      for (int i = 0; i < 5; i++) drive_press(8'(8'hE0 + i), 3);
      vectors++;
      if (bus.byte_idx !== 4'd5) begin
         errors++; $display("FAIL clrpress_pre: idx=%0d want 5", bus.byte_idx);
      end
      @(negedge clk);
      bus.Din = 8'h99;
      bus.btn = 1'b1;
      repeat (2) @(negedge clk);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      repeat (3) @(negedge clk);
      bus.btn = 1'b0;
      repeat (4) @(negedge clk);
      q.delete();
      vectors++;
      if (bus.byte_idx !== 4'd0 || bus.busy !== 1'b0 || bus.ready !== 1'b1 || bus.FA !== exp_fa) begin
         errors++; $display("FAIL clrpress_drop: idx=%0d busy=%b ready=%b FA=%h want 0/0/1 %h",
                            bus.byte_idx, bus.busy, bus.ready, bus.FA, exp_fa);
      end
      $display("clr_press: collision idx=%0d", bus.byte_idx);
   endtask

   task automatic test_done_reload();
      logic [7:0] bytes [NB] = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h80, 8'h00, 8'h00};
      logic [OP_W-1:0] old_fa;
      logic [OP_W-1:0] old_fb;
      old_fa = exp_fa;
      old_fb = exp_fb;
      for (int i = 0; i < NB; i++) begin
         drive_press(bytes[i], 3 + (i % 3));
         vectors++;
         if (i < NB - 1 && (bus.FA !== old_fa || bus.FB !== old_fb)) begin
            errors++; $display("FAIL reload_hold[%0d]: FA=%h FB=%h want %h %h", i, bus.FA, bus.FB, old_fa, old_fb);
         end else if (i == NB - 1 && (bus.FA !== 32'h80000000 || bus.FB !== 32'h7F800000)) begin
            errors++; $display("FAIL reload_final: FA=%h FB=%h want 80000000 7f800000", bus.FA, bus.FB);
         end
         $display("reload: byte %0d = %h FA=%h FB=%h", i, bytes[i], bus.FA, bus.FB);
      end
      vectors++;
      if (commit_seen !== exp_commits || bus.ready !== 1'b1) begin
         errors++; $display("FAIL reload_commit: commits=%0d ready=%b want %0d/1", commit_seen, bus.ready, exp_commits);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 6; i++) drive_press(8'($urandom_range(0, 255)), 3);
      vectors++;
      if (bus.byte_idx !== 4'd6) begin
         errors++; $display("FAIL areset_pre: idx=%0d want 6", bus.byte_idx);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      vectors++;
      if (bus.FA !== '0 || bus.FB !== '0 || bus.ready !== 1'b0 || bus.byte_idx !== 4'd0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL areset_now: FA=%h FB=%h ready=%b idx=%0d busy=%b want 0",
                            bus.FA, bus.FB, bus.ready, bus.byte_idx, bus.busy);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive_press(8'h5A, 3);
      vectors++;
      if (bus.byte_idx !== 4'd1 || bus.ready !== 1'b0 || bus.FA !== '0) begin
         errors++; $display("FAIL areset_after: idx=%0d ready=%b FA=%h want 1/0/0", bus.byte_idx, bus.ready, bus.FA);
      end
      drive_clr();
      vectors++;
      if (bus.ready !== 1'b0 || bus.byte_idx !== 4'd0) begin
         errors++; $display("FAIL areset_clr_idle: ready=%b idx=%0d want 0/0", bus.ready, bus.byte_idx);
      end
      $display("async_reset: checked");
   endtask

   task automatic test_random();
      for (int e = 0; e < 16; e++) begin
         for (int b = 0; b < NB; b++) begin
            drive_press(8'($urandom_range(0, 255)), $urandom_range(3, 12));
            if (q.size() != 0 && $urandom_range(0, 11) == 0) drive_clr();
            vectors++;
            if (bus.byte_idx !== 4'(q.size()) || bus.busy !== (q.size() != 0) ||
                bus.ready !== (had_pair && q.size() == 0)) begin
               errors++; $display("FAIL rand_status[%0d.%0d]: idx=%0d busy=%b ready=%b want %0d/%b/%b",
                                  e, b, bus.byte_idx, bus.busy, bus.ready,
                                  q.size(), q.size() != 0, had_pair && q.size() == 0);
            end
            vectors++;
            if (bus.FA !== exp_fa || bus.FB !== exp_fb || commit_seen !== exp_commits) begin
               errors++; $display("FAIL rand_ops[%0d.%0d]: FA=%h FB=%h commits=%0d want %h %h %0d",
                                  e, b, bus.FA, bus.FB, commit_seen, exp_fa, exp_fb, exp_commits);
            end
            if (q.size() == 0) break;
         end
         $display("random: entry %0d FA=%h FB=%h", e, bus.FA, bus.FB);
      end
      vectors++;
      if (commit_long !== 0) begin
         errors++; $display("FAIL commit_width: %0d multi-cycle pulses want 0", commit_long);
      end
   endtask

   initial begin
      bus.btn = 1'b0;
      bus.clr = 1'b0;
      bus.Din = 8'h00;
      repeat (3) @(negedge clk);
      test_reset();
      test_basic();
      test_hold();
      test_clr();
      test_clr_press();
      test_done_reload();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
